frame_monitor: RTL and testbench

- Receive-side counterpart of the on-chip frame generator.
- Sinks 16-bit AXI-Stream Ethernet-style frames on an ingress port and checks preamble/SFD, header and length framing.
- Captures the header fields and a 32-bit payload byte checksum of the last good frame, and counts good and bad frames.
- Results are exposed to software over the same 8-bit Avalon-MM slave style, so a loopback test compares generator and monitor checksums.

---
 rtl/frame_monitor.sv | 168 ++++++++++++++++
 tb/tb_frame_monitor.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/frame_monitor.sv
// frame_monitor: receive-side checker for 16-bit AXI-Stream Ethernet-style frames.
// Validates preamble/SFD, header and length framing, and captures the header and a
// 32-bit payload byte checksum of the last good frame. Good and bad frames are counted.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   writedata/write/chipselect/address/read/readdata
//                         8-bit Avalon-MM slave; readdata is registered, 1-cycle latency
//   ingress_port_*        AXI-Stream sink; tdata[15:8] is the earlier byte on the wire
module frame_monitor #(
    parameter int MAX_PAYLOAD = 1500,
    parameter int STALL_EVERY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [7:0]  address,
    input  logic        read,
    output logic [7:0]  readdata,
    input  logic [15:0] ingress_port_tdata,
    input  logic        ingress_port_tvalid,
    input  logic        ingress_port_tlast,
    output logic        ingress_port_tready
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, DROP} state_t;

    localparam int          SN    = STALL_EVERY > 0 ? STALL_EVERY : 1;
    localparam logic [15:0] MAX_L = 16'(MAX_PAYLOAD);

    state_t           state, nxt;
    logic [3:0]       cnt;
    logic [15:0]      rem, stall_cnt;
    logic [15:0][7:0] sh_hdr, hdr_next, hdr;
    logic [31:0]      sh_sum, sum_next, sum;
    logic [15:0]      good_count;
    logic [7:0]       err_count, rd_mux;
    logic             last_err, sticky_pre, sticky_len, drop_len, drop_len_n;
    logic             xfer, pre_err, len_hdr, final_b, frame_err;
    logic             good_end, bad_end, bad_len, clr;
    logic [3:0]       idx;
    logic [15:0]      l_beat, sh_len;
    logic             unused_ok;

    assign unused_ok = ^writedata;
    assign xfer      = ingress_port_tvalid && ingress_port_tready;
    assign clr       = chipselect && write && address == 8'd24;
    // Header beats 4..11 land in byte slots 0..15 of the register map in order.
    assign idx       = {cnt[2:0] - 3'd4, 1'b0};
    assign l_beat    = {ingress_port_tdata[7:0], ingress_port_tdata[15:8]};
    assign sh_len    = {sh_hdr[13], sh_hdr[12]};
    assign pre_err   = (state == IDLE && ingress_port_tdata != 16'hAAAA) ||
                       (state == PREAMBLE && ingress_port_tdata != (cnt == 4'd3 ? 16'hAAAB : 16'hAAAA));
    assign len_hdr   = state == HEADER && cnt == 4'd10 && l_beat > MAX_L;
    // The beat that must carry tlast: type beat of an empty frame, or the last payload beat.
    assign final_b   = (state == HEADER && cnt == 4'd11 && sh_len == 16'd0) ||
                       (state == PAYLOAD && rem < 16'd3);
    // A tlast mismatch covers both runts (early tlast) and long frames (missing tlast).
    assign frame_err = pre_err || len_hdr || (ingress_port_tlast != final_b);

    always_comb begin
        nxt        = state;
        good_end   = 1'b0;
        bad_end    = 1'b0;
        bad_len    = drop_len;
        drop_len_n = drop_len;
        if (xfer) begin
            if (state == DROP) begin
                bad_end = ingress_port_tlast;
                nxt     = ingress_port_tlast ? IDLE : DROP;
            end else if (frame_err) begin
                bad_len    = !pre_err;
                drop_len_n = !pre_err;
                bad_end    = ingress_port_tlast;
                nxt        = ingress_port_tlast ? IDLE : DROP;
            end else if (final_b) begin
                good_end = 1'b1;
                nxt      = IDLE;
            end else begin
                nxt = state == IDLE ? PREAMBLE :
                      state == PREAMBLE && cnt == 4'd3 ? HEADER :
                      state == HEADER && cnt == 4'd11 ? PAYLOAD : state;
            end
        end
    end

    always_comb begin
        hdr_next = sh_hdr;
        if (state == HEADER) begin
            hdr_next[idx]        = ingress_port_tdata[15:8];
            hdr_next[idx | 4'd1] = ingress_port_tdata[7:0];
        end
        // Shadow checksum is zero outside PAYLOAD, so each frame starts from 0.
        sum_next = state == PAYLOAD ?
                   sh_sum + 32'(ingress_port_tdata[15:8]) +
                   (rem > 16'd1 ? 32'(ingress_port_tdata[7:0]) : 32'd0) : 32'd0;
    end

    always_comb begin
        rd_mux = 8'h00;
        if (address < 8'd16)
            rd_mux = hdr[address[3:0]];
        else
            case (address)
                8'd16:   rd_mux = sum[7:0];
                8'd17:   rd_mux = sum[15:8];
                8'd18:   rd_mux = sum[23:16];
                8'd19:   rd_mux = sum[31:24];
                8'd20:   rd_mux = good_count[7:0];
                8'd21:   rd_mux = good_count[15:8];
                8'd22:   rd_mux = err_count;
                8'd23:   rd_mux = {4'b0, sticky_len, sticky_pre, last_err, state != IDLE};
                default: rd_mux = 8'h00;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            cnt                 <= '0;
            rem                 <= '0;
            stall_cnt           <= '0;
            sh_hdr              <= '0;
            hdr                 <= '0;
            sh_sum              <= '0;
            sum                 <= '0;
            good_count          <= '0;
            err_count           <= '0;
            last_err            <= 1'b0;
            sticky_pre          <= 1'b0;
            sticky_len          <= 1'b0;
            drop_len            <= 1'b0;
            readdata            <= '0;
            ingress_port_tready <= 1'b0;
        end else begin
            stall_cnt           <= stall_cnt == 16'(SN - 1) ? 16'd0 : stall_cnt + 16'd1;
            ingress_port_tready <= STALL_EVERY == 0 || stall_cnt != 16'(SN - 1);
            readdata            <= chipselect && read ? rd_mux : 8'h00;
            if (xfer) begin
                state    <= nxt;
                cnt      <= nxt == IDLE ? 4'd0 : cnt + 4'd1;
                rem      <= state == HEADER ? sh_len : rem - 16'd2;
                sh_hdr   <= hdr_next;
                sh_sum   <= sum_next;
                drop_len <= drop_len_n;
            end
            if (good_end) begin
                hdr        <= hdr_next;
                sum        <= sum_next;
                good_count <= good_count + 16'd1;
                last_err   <= 1'b0;
            end
            if (bad_end) begin
                err_count  <= err_count == 8'hFF ? 8'hFF : err_count + 8'd1;
                last_err   <= 1'b1;
                sticky_pre <= sticky_pre || !bad_len;
                sticky_len <= sticky_len || bad_len;
            end
            // A clear write overrides any counter or sticky update from a frame end.
            if (clr) begin
                good_count <= '0;
                err_count  <= '0;
                sticky_pre <= 1'b0;
                sticky_len <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_monitor.sv
// tb_frame_monitor: directed self-checking bench for frame_monitor (no stall and STALL_EVERY=3).
module tb_frame_monitor;
    logic        clk = 0;
    logic        reset = 1;
    logic [7:0]  writedata = 0, address = 0;
    logic        write = 0, read = 0;
    logic        cs[2];
    logic [15:0] td[2];
    logic        tv[2], tl[2];
    logic [7:0]  rd0, rd1, v;
    logic        tr0, tr1;
    int          passed = 0, total = 0, stalls = 0;
    logic [15:0] q[$];

    always #5 clk = ~clk;

    frame_monitor dut0 (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs[0]),
        .address(address), .read(read), .readdata(rd0), .ingress_port_tdata(td[0]),
        .ingress_port_tvalid(tv[0]), .ingress_port_tlast(tl[0]), .ingress_port_tready(tr0)
    );

    frame_monitor #(.STALL_EVERY(3)) dut1 (
        .clk(clk), .reset(reset), .writedata(writedata), .write(write), .chipselect(cs[1]),
        .address(address), .read(read), .readdata(rd1), .ingress_port_tdata(td[1]),
        .ingress_port_tvalid(tv[1]), .ingress_port_tlast(tl[1]), .ingress_port_tready(tr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic beat(input int s, input logic [15:0] d, input logic l);
        int n = 0;
        td[s] = d; tv[s] = 1; tl[s] = l;
        while (!(s != 0 ? tr1 : tr0) && n < 20) begin
            @(negedge clk);
            n++;
            stalls++;
        end
        if (n >= 20) check("tready_timeout", 0, 1);
        @(negedge clk);
        tv[s] = 0; tl[s] = 0;
    endtask

    task automatic send(input int s, input int last);
        foreach (q[i]) beat(s, q[i], i == last);
    endtask

    task automatic mk(input logic [7:0] d0, input logic [15:0] len, input logic [15:0] typ);
        logic [15:0] h[12];
        h = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAB, {d0, 8'h02}, 16'h0304, 16'h0506,
              16'h0A0B, 16'h0C0D, 16'h0E0F, {len[7:0], len[15:8]}, typ};
        q.delete();
        foreach (h[i]) q.push_back(h[i]);
    endtask

    task automatic check_reg(input int s, input logic [7:0] a, input logic [7:0] exp, input string tag);
        cs[s] = 1; read = 1; address = a;
        @(negedge clk);
        v = s != 0 ? rd1 : rd0;
        cs[s] = 0; read = 0;
        check(tag, v, exp);
    endtask

    task automatic wr(input int s, input logic [7:0] a, input logic [7:0] d);
        cs[s] = 1; write = 1; address = a; writedata = d;
        @(negedge clk);
        cs[s] = 0; write = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            cs[i] = 0; td[i] = 0; tv[i] = 0; tl[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("tready_in_reset", tr0, 0);
        check("readdata_in_reset", rd0, 0);
        reset = 0;
        @(negedge clk);
        check("tready_after_reset", tr0, 1);
        check_reg(0, 23, 8'h00, "status_reset");

        mk(8'h01, 4, 16'h0800); q.push_back(16'h1122); q.push_back(16'h3344);
        send(0, 13);
        check_reg(0, 16, 8'hAA, "s1_sum0");
        check_reg(0, 17, 8'h00, "s1_sum1");
        check_reg(0, 19, 8'h00, "s1_sum3");
        check_reg(0, 12, 8'h04, "s1_len_lo");
        check_reg(0, 13, 8'h00, "s1_len_hi");
        check_reg(0, 0, 8'h01, "s1_dst0");
        check_reg(0, 5, 8'h06, "s1_dst5");
        check_reg(0, 11, 8'h0F, "s1_src5");
        check_reg(0, 14, 8'h08, "s1_type0");
        check_reg(0, 20, 8'h01, "s1_good");
        check_reg(0, 23, 8'h00, "s1_status");

        wr(0, 24, 8'h00);
        mk(8'h01, 3, 16'h0800); q.push_back(16'h0102); q.push_back(16'h03FF);
        send(0, 13);
        check_reg(0, 16, 8'h06, "s2_sum_odd");
        check_reg(0, 20, 8'h01, "s2_good");
        check_reg(0, 12, 8'h03, "s2_len");

        q.delete();
        repeat (4) q.push_back(16'hAAAA);
        repeat (8) q.push_back(16'h5555);
        send(0, 11);
        check_reg(0, 22, 8'h01, "s3_err");
        check_reg(0, 23, 8'h06, "s3_status");
        check_reg(0, 12, 8'h03, "s3_len_kept");
        check_reg(0, 16, 8'h06, "s3_sum_kept");
        mk(8'h21, 4, 16'h0800); q.push_back(16'h1122); q.push_back(16'h3344);
        send(0, 13);
        check_reg(0, 23, 8'h04, "s3_status_after_good");
        check_reg(0, 20, 8'h02, "s3_good");
        check_reg(0, 0, 8'h21, "s3_dst0");

        wr(0, 24, 8'h00);
        mk(8'h01, 4, 16'h0800); q.push_back(16'h1122);
        send(0, 12);
        check_reg(0, 23, 8'h0A, "s4_runt_status");
        mk(8'h01, 2, 16'h0800); q.push_back(16'h1122); q.push_back(16'h3344); q.push_back(16'h5566);
        send(0, 14);
        check_reg(0, 22, 8'h02, "s4_err");
        check_reg(0, 23, 8'h0A, "s4_status");
        check_reg(0, 20, 8'h00, "s4_good");
        check_reg(0, 0, 8'h21, "s4_dst_kept");

        mk(8'h31, 2, 16'h86DD); q.push_back(16'h0102);
        for (int i = 0; i < 12; i++) beat(0, q[i], 0);
        td[0] = q[12]; tv[0] = 1; tl[0] = 1;
        cs[0] = 1; write = 1; address = 24; writedata = 8'h5A;
        @(negedge clk);
        tv[0] = 0; tl[0] = 0; cs[0] = 0; write = 0;
        check_reg(0, 20, 8'h00, "s5_good_cleared");
        check_reg(0, 22, 8'h00, "s5_err_cleared");
        check_reg(0, 23, 8'h00, "s5_status");
        check_reg(0, 0, 8'h31, "s5_dst0");
        check_reg(0, 14, 8'h86, "s5_type0");
        check_reg(0, 16, 8'h03, "s5_sum");
        check_reg(0, 30, 8'h00, "s5_unmapped");

        mk(8'h41, 4, 16'h0800); q.push_back(16'h1122);
        for (int i = 0; i < 13; i++) beat(0, q[i], 0);
        reset = 1;
        @(negedge clk);
        check("s6_tready_reset", tr0, 0);
        @(negedge clk);
        reset = 0;
        check_reg(0, 0, 8'h00, "s6_dst0");
        check_reg(0, 12, 8'h00, "s6_len");
        check_reg(0, 16, 8'h00, "s6_sum");
        check_reg(0, 20, 8'h00, "s6_good");
        check_reg(0, 23, 8'h00, "s6_status");
        beat(0, 16'h3344, 1);
        check_reg(0, 22, 8'h01, "s6_leftover_err");
        check_reg(0, 23, 8'h06, "s6_leftover_status");

        mk(8'h51, 1501, 16'h0800);
        send(0, 11);
        check_reg(0, 22, 8'h02, "max_len_err");
        check_reg(0, 23, 8'h0E, "max_len_status");
        check_reg(0, 0, 8'h00, "max_len_dst_kept");

        stalls = 0;
        mk(8'h01, 4, 16'h0800); q.push_back(16'h1122); q.push_back(16'h3344);
        send(1, 13);
        check("stall_seen", stalls != 0, 1);
        check_reg(1, 16, 8'hAA, "st_sum0");
        check_reg(1, 17, 8'h00, "st_sum1");
        check_reg(1, 20, 8'h01, "st_good");
        mk(8'h01, 0, 16'h0800);
        send(1, 11);
        check_reg(1, 20, 8'h02, "st_l0_good");
        check_reg(1, 16, 8'h00, "st_l0_sum");
        check_reg(1, 12, 8'h00, "st_l0_len");
        check_reg(1, 23, 8'h00, "st_l0_status");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
